// File: rtl/lfsr_gen.sv
// Dual-mode (Fibonacci/Galois) LFSR with IDLE/RUN/LOCK control.
// Optional period measurement is built when LFSR_GEN_PERIOD_CNT_EN is defined.
module lfsr_gen #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] FTAPS      = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] GTAPS      = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1'b1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] w,
  output logic             valid,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] stepped_s;
  logic             valid_r;
  logic             lockup_r;

  function automatic logic parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], parity(v & FTAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? GTAPS : {WIDTH{1'b0}});
  endfunction

  // Next-state and next-value selection; load has priority over stepping.
  always_comb begin
    state_s   = state_r;
    w_s       = w_r;
    stepped_s = mode ? gal_step(w_r) : fib_step(w_r);
    if (load) begin
      w_s     = seed;
      state_s = (seed != {WIDTH{1'b0}}) ? RUN : LOCK;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (en) begin
            w_s     = stepped_s;
            state_s = (stepped_s == {WIDTH{1'b0}}) ? LOCK : RUN;
          end else begin
            state_s = RUN;
          end
        end
        LOCK: begin
          w_s     = {WIDTH{1'b0}};
          state_s = LOCK;
        end
        default: begin
          w_s     = RESET_SEED;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, value and status flags; flags track the next state so they align with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      w_r      <= RESET_SEED;
      valid_r  <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      w_r      <= w_s;
      valid_r  <= (state_s == RUN);
      lockup_r <= (state_s == LOCK);
    end
  end

  assign w      = w_r;
  assign valid  = valid_r;
  assign lockup = lockup_r;

`ifdef LFSR_GEN_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] seed_last_r;
  logic [WIDTH-1:0] period_r;
  logic             wrap_r;
  logic             step_s;

  assign step_s = !load && en && (state_r == RUN);

  // Period measurement: a step landing back on the loaded seed closes one period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= {WIDTH{1'b0}};
      seed_last_r <= RESET_SEED;
      period_r    <= {WIDTH{1'b0}};
      wrap_r      <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (load) begin
        cnt_r       <= {WIDTH{1'b0}};
        seed_last_r <= seed;
      end else if (step_s) begin
        if (w_s == seed_last_r) begin
          wrap_r   <= 1'b1;
          period_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
          cnt_r    <= {WIDTH{1'b0}};
        end else begin
          cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign wrap   = wrap_r;
  assign period = period_r;
`else
  assign wrap   = 1'b0;
  assign period = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen (WIDTH=8, default taps).
module tb_lfsr_gen;

  logic       clk;
  logic       reset;
  logic [7:0] seed;
  logic       load;
  logic       en;
  logic       mode;
  logic [7:0] w;
  logic       valid;
  logic       lockup;
  logic       wrap;
  logic [7:0] period;

  int n_cmp;
  int n_bad;
  int wraps;

  lfsr_gen #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .en(en),
    .mode(mode), .w(w), .valid(valid), .lockup(lockup), .wrap(wrap),
    .period(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; wraps = 0;
    reset = 1'b1; seed = 8'h00; load = 1'b0; en = 1'b0; mode = 1'b0;
    #3;
    check("rst_w", {24'd0, w}, 32'h01);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_lockup", {31'd0, lockup}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_period", {24'd0, period}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores en
    en = 1'b1;
    tick();
    check("idle_w", {24'd0, w}, 32'h01);
    check("idle_valid", {31'd0, valid}, 32'd0);

    // Fibonacci run from 0x01
    load = 1'b1; seed = 8'h01; en = 1'b0; mode = 1'b0;
    tick();
    check("fib_load_w", {24'd0, w}, 32'h01);
    check("fib_load_valid", {31'd0, valid}, 32'd1);
    load = 1'b0; en = 1'b1;
    tick(); check("fib_s1", {24'd0, w}, 32'h02);
    tick(); check("fib_s2", {24'd0, w}, 32'h04);
    tick(); check("fib_s3", {24'd0, w}, 32'h08);
    tick(); check("fib_s4", {24'd0, w}, 32'h11);
    check("fib_valid", {31'd0, valid}, 32'd1);
    en = 1'b0;
    tick(); check("hold_w", {24'd0, w}, 32'h11);

    // Galois step from 0x80
    load = 1'b1; seed = 8'h80; mode = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); check("gal_s1", {24'd0, w}, 32'h1D);

    // Mode switch between steps: Galois 0x81 -> 0x1F, then Fibonacci -> 0x3E
    load = 1'b1; seed = 8'h81; en = 1'b0; mode = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); check("mix_gal", {24'd0, w}, 32'h1F);
    mode = 1'b0;
    tick(); check("mix_fib", {24'd0, w}, 32'h3E);

    // Load wins over en in the same cycle
    load = 1'b1; en = 1'b1; seed = 8'h3C;
    tick(); check("load_en_w", {24'd0, w}, 32'h3C);

    // Zero seed locks; en is ignored until a new load
    seed = 8'h00;
    tick();
    check("lock_lockup", {31'd0, lockup}, 32'd1);
    check("lock_valid", {31'd0, valid}, 32'd0);
    load = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    check("lock_w", {24'd0, w}, 32'h00);
    check("lock_hold", {31'd0, lockup}, 32'd1);
    load = 1'b1; seed = 8'h05;
    tick();
    check("unlock_w", {24'd0, w}, 32'h05);
    check("unlock_valid", {31'd0, valid}, 32'd1);
    check("unlock_lockup", {31'd0, lockup}, 32'd0);

    // Full period in each mode
    for (int m = 0; m < 2; m++) begin
      load = 1'b1; seed = 8'h01; en = 1'b0; mode = m[0];
      tick();
      load = 1'b0; en = 1'b1; wraps = 0;
      for (int i = 1; i <= 255; i++) begin
        tick();
`ifdef LFSR_GEN_PERIOD_CNT_EN
        check("wrap_edge", {31'd0, wrap}, (i == 255) ? 32'd1 : 32'd0);
`else
        check("wrap_tied", {31'd0, wrap}, 32'd0);
`endif
        if (wrap) wraps++;
      end
      check("period_w", {24'd0, w}, 32'h01);
`ifdef LFSR_GEN_PERIOD_CNT_EN
      check("period_val", {24'd0, period}, 32'd255);
      check("wrap_count", wraps, 32'd1);
`else
      check("period_tied", {24'd0, period}, 32'd0);
`endif
    end

    // Asynchronous reset between edges mid-run
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_w", {24'd0, w}, 32'h01);
    check("async_valid", {31'd0, valid}, 32'd0);
    check("async_period", {24'd0, period}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_w", {24'd0, w}, 32'h01);
    check("post_rst_valid", {31'd0, valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
